pooling_band_scheduler: RTL and testbench

Sequences one pooling instruction through the pooling input address generator (IAGU) as a series of output-row bands. It accepts an instruction on a valid/ready handshake and splits `out_y_length` into bands of at most `MAX_BAND` output rows. For each band it drives the IAGU configuration and a one-cycle `start_calculate`, then counts the IAGU's `pooling_out` pulses to detect band completion. It sits between the decoder/schedule logic and the IAGU, and also reports instruction done, busy and error.

---
 rtl/pooling_band_scheduler_if.sv | 47 ++++
 rtl/pooling_band_scheduler.sv | 174 +++++++++++++++++
 tb/tb_pooling_band_scheduler.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pooling_band_scheduler_if.sv
// rtl/pooling_band_scheduler_if.sv - instruction, IAGU configuration and status bundle for the pooling band scheduler
interface pooling_band_scheduler_if;
  // instruction handshake from the decoder/schedule logic
  logic        inst_valid;
  logic        inst_ready;
  logic [12:0] inst_addr_start;
  logic [7:0]  inst_in_x;
  logic [7:0]  inst_out_x;
  logic [7:0]  inst_out_y;
  logic [7:0]  inst_piece;
  logic [3:0]  inst_kernel;
  logic [1:0]  inst_stride;

  // IAGU configuration and launch
  logic        start_calculate;
  logic [12:0] addr_start_d;
  logic [7:0]  in_x_length;
  logic [7:0]  out_x_length;
  logic [7:0]  out_y_length;
  logic [7:0]  in_piece;
  logic [3:0]  i_kernel;
  logic [1:0]  i_stride;

  // IAGU window-complete pulse
  logic        pooling_out;

  // status
  logic        busy;
  logic        done;
  logic        err;

  // scheduler side
  modport master (
    input  inst_valid, inst_addr_start, inst_in_x, inst_out_x, inst_out_y,
           inst_piece, inst_kernel, inst_stride, pooling_out,
    output inst_ready, start_calculate, addr_start_d, in_x_length, out_x_length,
           out_y_length, in_piece, i_kernel, i_stride, busy, done, err
  );

  // decoder + IAGU side
  modport slave (
    output inst_valid, inst_addr_start, inst_in_x, inst_out_x, inst_out_y,
           inst_piece, inst_kernel, inst_stride, pooling_out,
    input  inst_ready, start_calculate, addr_start_d, in_x_length, out_x_length,
           out_y_length, in_piece, i_kernel, i_stride, busy, done, err
  );
endinterface

// File: rtl/pooling_band_scheduler.sv
// rtl/pooling_band_scheduler.sv - splits one pooling instruction into output-row bands for the IAGU
module pooling_band_scheduler #(
  parameter int unsigned MAX_BAND = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  pooling_band_scheduler_if.master        bus
);

  localparam logic [7:0] MAX_B = MAX_BAND[7:0];

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_GAP    = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  in_x_q, in_x_d;
  logic [7:0]  out_x_q, out_x_d;
  logic [7:0]  piece_q, piece_d;
  logic [3:0]  kernel_q, kernel_d;
  logic [1:0]  stride_q, stride_d;
  logic [7:0]  rows_left_q, rows_left_d;
  logic [12:0] band_base_q, band_base_d;
  logic [7:0]  band_rows_q, band_rows_d;
  logic [12:0] addr_out_q, addr_out_d;
  logic [23:0] target_q, target_d;
  logic [23:0] win_cnt_q, win_cnt_d;
  logic        err_q, err_d;

  logic        zero_field;
  logic        load_band;
  logic [23:0] win_inc;
  logic [12:0] addr_step;

  assign zero_field = (bus.inst_in_x == 8'd0) || (bus.inst_out_x == 8'd0) ||
                      (bus.inst_out_y == 8'd0) || (bus.inst_piece == 8'd0) ||
                      (bus.inst_kernel == 4'd0) || (bus.inst_stride == 2'd0);

  assign win_inc = win_cnt_q + 24'd1;

  // Only the low 13 bits of the band address step survive the wrap, and those
  // depend only on the low 13 bits of each factor, so a 13-bit product is exact.
  assign addr_step = 13'(band_rows_q) * 13'(stride_q) * 13'(in_x_q) * 13'(piece_q);

  // Next-state, band bookkeeping and error detection
  always_comb begin
    state_d     = state_q;
    in_x_d      = in_x_q;
    out_x_d     = out_x_q;
    piece_d     = piece_q;
    kernel_d    = kernel_q;
    stride_d    = stride_q;
    rows_left_d = rows_left_q;
    band_base_d = band_base_q;
    band_rows_d = band_rows_q;
    addr_out_d  = addr_out_q;
    target_d    = target_q;
    win_cnt_d   = win_cnt_q;
    err_d       = 1'b0;
    load_band   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.inst_valid) begin
          if (zero_field) begin
            err_d = 1'b1;
          end else begin
            in_x_d      = bus.inst_in_x;
            out_x_d     = bus.inst_out_x;
            piece_d     = bus.inst_piece;
            kernel_d    = bus.inst_kernel;
            stride_d    = bus.inst_stride;
            rows_left_d = bus.inst_out_y;
            band_base_d = bus.inst_addr_start;
            load_band   = 1'b1;
            state_d     = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.pooling_out) begin
          win_cnt_d = win_inc;
          if (win_inc == target_q) begin
            rows_left_d = rows_left_q - band_rows_q;
            band_base_d = band_base_q + addr_step;
            state_d     = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (rows_left_q != 8'd0) begin
          load_band = 1'b1;
          state_d   = S_LAUNCH;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The IAGU only listens for windows while a band runs.
    if (bus.pooling_out && (state_q != S_RUN)) begin
      err_d = 1'b1;
    end

    // Band configuration is loaded on the edge that enters LAUNCH so it is
    // already valid alongside start_calculate and then held until the next band.
    if (load_band) begin
      band_rows_d = (rows_left_d > MAX_B) ? MAX_B : rows_left_d;
      addr_out_d  = band_base_d;
      target_d    = 24'(out_x_d) * 24'(piece_d) * 24'(band_rows_d);
      win_cnt_d   = 24'd0;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      in_x_q      <= '0;
      out_x_q     <= '0;
      piece_q     <= '0;
      kernel_q    <= '0;
      stride_q    <= '0;
      rows_left_q <= '0;
      band_base_q <= '0;
      band_rows_q <= '0;
      addr_out_q  <= '0;
      target_q    <= '0;
      win_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_x_q      <= in_x_d;
      out_x_q     <= out_x_d;
      piece_q     <= piece_d;
      kernel_q    <= kernel_d;
      stride_q    <= stride_d;
      rows_left_q <= rows_left_d;
      band_base_q <= band_base_d;
      band_rows_q <= band_rows_d;
      addr_out_q  <= addr_out_d;
      target_q    <= target_d;
      win_cnt_q   <= win_cnt_d;
      err_q       <= err_d;
    end
  end

  assign bus.inst_ready      = (state_q == S_IDLE);
  assign bus.busy            = (state_q != S_IDLE);
  assign bus.start_calculate = (state_q == S_LAUNCH);
  assign bus.done            = (state_q == S_FINISH);
  assign bus.err             = err_q;
  assign bus.addr_start_d    = addr_out_q;
  assign bus.in_x_length     = in_x_q;
  assign bus.out_x_length    = out_x_q;
  assign bus.out_y_length    = band_rows_q;
  assign bus.in_piece        = piece_q;
  assign bus.i_kernel        = kernel_q;
  assign bus.i_stride        = stride_q;

endmodule

// File: tb/tb_pooling_band_scheduler.sv
// tb/tb_pooling_band_scheduler.sv - directed self-checking bench for pooling_band_scheduler
module tb_pooling_band_scheduler;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   done_cnt;

  pooling_band_scheduler_if bus();

  pooling_band_scheduler #(.MAX_BAND(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count done pulses away from the active edge
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_inst(input logic [12:0] addr, input logic [7:0] in_x,
                           input logic [7:0] out_x, input logic [7:0] out_y,
                           input logic [7:0] piece, input logic [3:0] kernel,
                           input logic [1:0] stride);
    bus.inst_addr_start = addr;
    bus.inst_in_x       = in_x;
    bus.inst_out_x      = out_x;
    bus.inst_out_y      = out_y;
    bus.inst_piece      = piece;
    bus.inst_kernel     = kernel;
    bus.inst_stride     = stride;
    bus.inst_valid      = 1'b1;
    tick();
    bus.inst_valid      = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      bus.pooling_out = 1'b1;
      tick();
    end
    bus.pooling_out = 1'b0;
  endtask

  // in_x=8 out_x=3 out_y=10 piece=2 kernel=2 stride=2 addr=0x100
  task automatic run_multi(input string pfx);
    int d0;
    d0 = done_cnt;
    send_inst(13'h100, 8'd8, 8'd3, 8'd10, 8'd2, 4'd2, 2'd2);
    chk({pfx, "_b1_start"}, 32'(bus.start_calculate), 32'd1);
    chk({pfx, "_b1_rows"},  32'(bus.out_y_length), 32'd4);
    chk({pfx, "_b1_addr"},  32'(bus.addr_start_d), 32'h100);
    chk({pfx, "_in_x"},     32'(bus.in_x_length), 32'd8);
    chk({pfx, "_kernel"},   32'(bus.i_kernel), 32'd2);
    tick();
    chk({pfx, "_run_start_low"}, 32'(bus.start_calculate), 32'd0);
    pulses(24);
    chk({pfx, "_gap1_start"}, 32'(bus.start_calculate), 32'd0);
    chk({pfx, "_gap1_busy"},  32'(bus.busy), 32'd1);
    tick();
    chk({pfx, "_b2_start"}, 32'(bus.start_calculate), 32'd1);
    chk({pfx, "_b2_rows"},  32'(bus.out_y_length), 32'd4);
    chk({pfx, "_b2_addr"},  32'(bus.addr_start_d), 32'h180);
    tick();
    pulses(24);
    tick();
    chk({pfx, "_b3_start"}, 32'(bus.start_calculate), 32'd1);
    chk({pfx, "_b3_rows"},  32'(bus.out_y_length), 32'd2);
    chk({pfx, "_b3_addr"},  32'(bus.addr_start_d), 32'h200);
    tick();
    pulses(12);
    chk({pfx, "_gap3_done"}, 32'(bus.done), 32'd0);
    tick();
    chk({pfx, "_finish_done"}, 32'(bus.done), 32'd1);
    tick();
    chk({pfx, "_idle_ready"}, 32'(bus.inst_ready), 32'd1);
    chk({pfx, "_idle_busy"},  32'(bus.busy), 32'd0);
    chk({pfx, "_done_count"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    n_checks = 0;
    n_pass   = 0;
    done_cnt = 0;
    rst             = 1'b0;
    bus.inst_valid  = 1'b0;
    bus.inst_addr_start = '0;
    bus.inst_in_x   = '0;
    bus.inst_out_x  = '0;
    bus.inst_out_y  = '0;
    bus.inst_piece  = '0;
    bus.inst_kernel = '0;
    bus.inst_stride = '0;
    bus.pooling_out = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // reset state
    chk("rst_ready", 32'(bus.inst_ready), 32'd1);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_start", 32'(bus.start_calculate), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_err",   32'(bus.err), 32'd0);
    chk("rst_addr",  32'(bus.addr_start_d), 32'd0);

    // multi-band instruction
    run_multi("multi");

    // single band, IAGU silent for 100 cycles
    send_inst(13'h040, 8'd5, 8'd1, 8'd3, 8'd1, 4'd3, 2'd1);
    chk("single_rows", 32'(bus.out_y_length), 32'd3);
    chk("single_addr", 32'(bus.addr_start_d), 32'h040);
    tick();
    d0 = done_cnt;
    repeat (100) tick();
    chk("idle_iagu_busy", 32'(bus.busy), 32'd1);
    chk("idle_iagu_done", 32'(done_cnt - d0), 32'd0);
    chk("idle_iagu_start", 32'(bus.start_calculate), 32'd0);
    pulses(3);
    tick();
    chk("single_done", 32'(bus.done), 32'd1);
    tick();

    // zero-field rejection
    send_inst(13'h010, 8'd4, 8'd1, 8'd2, 8'd0, 4'd2, 2'd1);
    chk("zero_err",   32'(bus.err), 32'd1);
    chk("zero_start", 32'(bus.start_calculate), 32'd0);
    chk("zero_busy",  32'(bus.busy), 32'd0);
    chk("zero_ready", 32'(bus.inst_ready), 32'd1);
    tick();
    chk("zero_err_once", 32'(bus.err), 32'd0);
    chk("zero_still_idle", 32'(bus.busy), 32'd0);

    // stray pulse in GAP: bands of 4 and 1 rows, each target = rows
    send_inst(13'h010, 8'd4, 8'd1, 8'd5, 8'd1, 4'd2, 2'd1);
    tick();
    pulses(4);
    bus.pooling_out = 1'b1;
    tick();
    bus.pooling_out = 1'b0;
    chk("gap_stray_err",   32'(bus.err), 32'd1);
    chk("gap_stray_start", 32'(bus.start_calculate), 32'd1);
    chk("gap_stray_rows",  32'(bus.out_y_length), 32'd1);
    chk("gap_stray_addr",  32'(bus.addr_start_d), 32'h020);
    tick();
    chk("gap_stray_err_once", 32'(bus.err), 32'd0);
    pulses(1);
    tick();
    chk("gap_stray_done", 32'(bus.done), 32'd1);
    tick();

    // stray pulse in IDLE
    bus.pooling_out = 1'b1;
    tick();
    bus.pooling_out = 1'b0;
    chk("idle_stray_err",  32'(bus.err), 32'd1);
    chk("idle_stray_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("idle_stray_err_once", 32'(bus.err), 32'd0);

    // reset mid-band, inside RUN of band 2
    send_inst(13'h100, 8'd8, 8'd3, 8'd10, 8'd2, 4'd2, 2'd2);
    tick();
    pulses(24);
    tick();
    tick();
    pulses(5);
    d0 = done_cnt;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_ready", 32'(bus.inst_ready), 32'd1);
    chk("midrst_busy",  32'(bus.busy), 32'd0);
    chk("midrst_start", 32'(bus.start_calculate), 32'd0);
    chk("midrst_addr",  32'(bus.addr_start_d), 32'd0);
    chk("midrst_rows",  32'(bus.out_y_length), 32'd0);
    chk("midrst_in_x",  32'(bus.in_x_length), 32'd0);
    chk("midrst_err",   32'(bus.err), 32'd0);
    repeat (5) tick();
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    run_multi("restart");

    // address wrap: band step = 4 * 1 * 64 * 2 = 512
    send_inst(13'h1F80, 8'd64, 8'd1, 8'd5, 8'd2, 4'd2, 2'd1);
    chk("wrap_b1_addr", 32'(bus.addr_start_d), 32'h1F80);
    tick();
    pulses(8);
    tick();
    chk("wrap_b2_start", 32'(bus.start_calculate), 32'd1);
    chk("wrap_b2_addr",  32'(bus.addr_start_d), 32'h0180);
    chk("wrap_b2_rows",  32'(bus.out_y_length), 32'd1);
    tick();
    pulses(2);
    tick();
    chk("wrap_done", 32'(bus.done), 32'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
